// File: rtl/tt_check_pkg.sv
// Shared types and sizing helpers for the truth-table response checker.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Truth-table width for a given number of DUT inputs.
  function automatic int unsigned tw_of(input int unsigned n_in);
    return 32'(1) << n_in;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes its next value.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX_VAL)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign count_nxt_c = count_d;

endmodule

// File: rtl/truth_table_checker.sv
// Builds the observed truth table of a combinational DUT from (vector, y) samples
// and compares it against a golden table once coverage is complete or the budget expires.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int unsigned N_IN = 3,
  localparam int unsigned TW = tw_of(N_IN),
  parameter logic [TW-1:0] EXPECTED = 8'h5F,
  parameter int unsigned MAX_SAMPLES = 64,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             in_y,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             conflict,
  output logic             timeout,
  output logic [TW-1:0]    covered,
  output logic [TW-1:0]    table_out,
  output logic [TW-1:0]    mismatch_mask,
  output logic [CNT_W-1:0] sample_count
);

  state_e        state_q, state_d;
  logic [TW-1:0] covered_q, covered_d;
  logic [TW-1:0] table_q, table_d;
  logic [TW-1:0] mask_q, mask_d;
  logic          pass_q, pass_d;
  logic          conflict_q, conflict_d;
  logic          timeout_q, timeout_d;
  logic          done_q, done_d;

  logic             accept;
  logic [CNT_W-1:0] count_nxt;

  assign in_ready = (state_q == COLLECT) & ~start;
  assign accept   = in_valid & in_ready;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_count (
    .clk         (clk),
    .rst         (rst),
    .clr         (start),
    .en          (accept),
    .count       (sample_count),
    .count_nxt_c (count_nxt)
  );

  always_comb begin
    state_d    = state_q;
    covered_d  = covered_q;
    table_d    = table_q;
    mask_d     = mask_q;
    pass_d     = pass_q;
    conflict_d = conflict_q;
    timeout_d  = timeout_q;
    done_d     = done_q;

    if (start) begin
      // start from any state opens a fresh run
      state_d    = COLLECT;
      covered_d  = '0;
      table_d    = '0;
      mask_d     = '0;
      pass_d     = 1'b0;
      conflict_d = 1'b0;
      timeout_d  = 1'b0;
      done_d     = 1'b0;
    end else if (accept) begin
      covered_d[in_vec] = 1'b1;
      if (!covered_q[in_vec]) begin
        table_d[in_vec] = in_y;
      end else if (table_q[in_vec] != in_y) begin
        conflict_d = 1'b1;
      end

      // completion judged on the post-sample values; coverage beats timeout
      if (&covered_d) begin
        state_d = DONE;
        done_d  = 1'b1;
        mask_d  = (table_d ^ EXPECTED) & covered_d;
        pass_d  = ~conflict_d & (table_d == EXPECTED);
      end else if (count_nxt == CNT_W'(MAX_SAMPLES)) begin
        state_d   = DONE;
        done_d    = 1'b1;
        timeout_d = 1'b1;
        mask_d    = (table_d ^ EXPECTED) & covered_d;
        pass_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      covered_q  <= '0;
      table_q    <= '0;
      mask_q     <= '0;
      pass_q     <= 1'b0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      covered_q  <= covered_d;
      table_q    <= table_d;
      mask_q     <= mask_d;
      pass_q     <= pass_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
    end
  end

  assign busy          = (state_q == COLLECT);
  assign done          = done_q;
  assign pass          = pass_q;
  assign conflict      = conflict_q;
  assign timeout       = timeout_q;
  assign covered       = covered_q;
  assign table_out     = table_q;
  assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized and directed bench for truth_table_checker against a sample-history reference model.
module tb_truth_table_checker;

  localparam int unsigned N_IN    = 3;
  localparam int unsigned TW      = 8;
  localparam int unsigned MAX_S   = 64;
  localparam int unsigned CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [N_IN-1:0]  in_vec = '0;
  logic             in_y = 1'b0;
  logic             in_ready, busy, done, pass, conflict, timeout;
  logic [TW-1:0]    covered, table_out, mismatch_mask;
  logic [CNT_W-1:0] sample_count;

  int checks = 0;
  int errors = 0;

  // model: every accepted sample of the current run, in order
  int unsigned hist_vec[$];
  bit          hist_y[$];
  bit          run_open = 1'b0;

  always #5 clk = ~clk;

  truth_table_checker #(
    .N_IN        (N_IN),
    .EXPECTED    (8'h5F),
    .MAX_SAMPLES (MAX_S),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_vec        (in_vec),
    .in_y          (in_y),
    .in_ready      (in_ready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .conflict      (conflict),
    .timeout       (timeout),
    .covered       (covered),
    .table_out     (table_out),
    .mismatch_mask (mismatch_mask),
    .sample_count  (sample_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // golden rule: y = !(a & c) with vector = {a,b,c}
  function automatic bit golden_y(input int unsigned v);
    return !(v[2] && v[0]);
  endfunction

  function automatic logic [TW-1:0] golden_table();
    logic [TW-1:0] t = '0;
    for (int v = 0; v < TW; v++) t[v] = golden_y(v);
    return t;
  endfunction

  // Derive coverage, first-seen table and conflict from the run history.
  function automatic void eval_hist(output logic [TW-1:0] cov, output logic [TW-1:0] tab,
                                    output bit conf);
    cov  = '0;
    tab  = '0;
    conf = 1'b0;
    for (int i = 0; i < hist_vec.size(); i++) begin
      if (!cov[hist_vec[i]]) begin
        cov[hist_vec[i]] = 1'b1;
        tab[hist_vec[i]] = hist_y[i];
      end else if (tab[hist_vec[i]] != hist_y[i]) begin
        conf = 1'b1;
      end
    end
  endfunction

  function automatic bit model_done();
    logic [TW-1:0] cov, tab;
    bit conf;
    eval_hist(cov, tab, conf);
    return run_open && ((cov == '1) || (hist_vec.size() >= MAX_S));
  endfunction

  task automatic compare_all(input string tag);
    logic [TW-1:0] cov, tab;
    bit conf, fin, full, collecting;
    eval_hist(cov, tab, conf);
    fin        = model_done();
    full       = (cov == '1);
    collecting = run_open && !fin;
    check_eq({tag, "/busy"},     busy,         collecting);
    check_eq({tag, "/ready"},    in_ready,     collecting && !start);
    check_eq({tag, "/done"},     done,         fin);
    check_eq({tag, "/covered"},  covered,      cov);
    check_eq({tag, "/table"},    table_out,    tab);
    check_eq({tag, "/conflict"}, conflict,     conf);
    check_eq({tag, "/count"},    sample_count, hist_vec.size());
    check_eq({tag, "/timeout"},  timeout,      fin && !full);
    check_eq({tag, "/mask"},     mismatch_mask,
             fin ? ((tab ^ golden_table()) & cov) : '0);
    check_eq({tag, "/pass"},     pass,
             fin && full && !conf && (tab == golden_table()));
  endtask

  // One clock: check outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic cycle(input string tag, input bit r, input bit st, input bit v,
                       input int unsigned vec, input bit y);
    @(negedge clk);
    compare_all(tag);
    rst      = r;
    start    = st;
    in_valid = v;
    in_vec   = N_IN'(vec);
    in_y     = y;
    if (r) begin
      hist_vec.delete(); hist_y.delete(); run_open = 1'b0;
    end else if (st) begin
      hist_vec.delete(); hist_y.delete(); run_open = 1'b1;
    end else if (v && run_open && !model_done()) begin
      hist_vec.push_back(vec); hist_y.push_back(y);
    end
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic send(input string tag, input int unsigned vec, input bit y);
    cycle(tag, 1'b0, 1'b0, 1'b1, vec, y);
  endtask

  task automatic begin_run(input string tag);
    cycle(tag, 1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic sweep(input string tag, input int unsigned flip_vec);
    for (int v = 0; v < TW; v++) send(tag, v, golden_y(v) ^ (v == flip_vec));
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // mid-run reset returns to an idle, empty checker
    idle("t1");
    begin_run("t1");
    for (int v = 0; v < 3; v++) send("t1", v, golden_y(v));
    cycle("t1", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle("t1");
    check_eq("t1_busy", busy, 0);
    check_eq("t1_ready", in_ready, 0);
    check_eq("t1_covered", covered, 0);
    check_eq("t1_count", sample_count, 0);

    // clean exhaustive sweep
    begin_run("t2");
    sweep("t2", TW);
    idle("t2");
    check_eq("t2_done", done, 1);
    check_eq("t2_table", table_out, 8'h5F);
    check_eq("t2_pass", pass, 1);
    check_eq("t2_count", sample_count, 8);
    check_eq("t2_mask", mismatch_mask, 0);

    // wrong output at vector 7
    begin_run("t3");
    sweep("t3", 7);
    idle("t3");
    check_eq("t3_table", table_out, 8'hDF);
    check_eq("t3_mask", mismatch_mask, 8'h80);
    check_eq("t3_pass", pass, 0);

    // vector 2 repeated with differing y
    begin_run("t4");
    send("t4", 2, 1'b1);
    send("t4", 2, 1'b0);
    for (int v = 0; v < TW; v++) if (v != 2) send("t4", v, golden_y(v));
    idle("t4");
    check_eq("t4_conflict", conflict, 1);
    check_eq("t4_table2", table_out[2], 1);
    check_eq("t4_pass", pass, 0);
    check_eq("t4_count", sample_count, 9);
    check_eq("t4_done", done, 1);

    // budget exhaustion on a single vector
    begin_run("t5");
    for (int i = 0; i < MAX_S; i++) send("t5", 0, 1'b1);
    idle("t5");
    check_eq("t5_timeout", timeout, 1);
    check_eq("t5_done", done, 1);
    check_eq("t5_covered", covered, 8'h01);
    check_eq("t5_pass", pass, 0);
    check_eq("t5_count", sample_count, MAX_S);

    // restart while collecting drops the concurrent sample
    begin_run("t6");
    send("t6", 3, 1'b1);
    cycle("t6", 1'b0, 1'b1, 1'b1, 4, 1'b1);
    #1 check_eq("t6_ready_on_start", in_ready, 0);
    idle("t6");
    check_eq("t6_count", sample_count, 0);
    check_eq("t6_covered", covered, 0);
    sweep("t6", TW);
    idle("t6");
    check_eq("t6_pass", pass, 1);

    // randomized traffic against the history model
    begin_run("rnd");
    for (int c = 0; c < 3000; c++) begin
      int unsigned r = $urandom_range(0, 199);
      int unsigned v = $urandom_range(0, TW - 1);
      bit y = golden_y(v) ^ ($urandom_range(0, 15) == 0);
      if (r < 2)       cycle("rnd", 1'b1, 1'b0, 1'b0, 0, 1'b0);
      else if (r < 6)  cycle("rnd", 1'b0, 1'b1, $urandom_range(0, 1) == 1, v, y);
      else if (r < 40) idle("rnd");
      else             send("rnd", v, y);
    end
    idle("rnd_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
